// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word, PC step.
// Optional build macro used by the top: IFU_PERF_CNT_EN (adds fetch/stall counters).
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: bubble has priority over load; neither means hold.
module if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      pc_q       <= 32'd0;
      pc_plus4_q <= PC_INC;
    end else if (bubble_i) begin
      // PC fields keep their last value; only VALID qualifies them
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      valid_q    <= 1'b1;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + PC_INC;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing, imem request FSM, one-entry skid buffer, redirects.
// Define IFU_PERF_CNT_EN to add the FETCH_COUNT / STALL_COUNT performance counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output ifu_state_e  STATE_DBG,
  output logic        VALID
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] STALL_COUNT
`endif
);

  // Memory handshake: a request is held (REQ=1, ADDR stable) until the cycle
  // with IMEM_READY=1, which delivers IMEM_RDATA and completes it.
  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] skid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] tgt_q;
  logic        req_q;

  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = IMEM_RDATA;
    ifid_pc     = pc_q;
    case (state_q)
      IDLE:  ifid_bubble = BRANCH_TAKEN;
      FETCH: begin
        if (BRANCH_TAKEN)                 ifid_bubble = 1'b1;
        else if (IMEM_READY && !STALL)    ifid_load   = 1'b1;
        else if (!IMEM_READY && !STALL)   ifid_bubble = 1'b1;
      end
      HOLD: begin
        ifid_instr = skid_q;
        ifid_pc    = skid_pc_q;
        if (BRANCH_TAKEN)  ifid_bubble = 1'b1;
        else if (!STALL)   ifid_load   = 1'b1;
      end
      DRAIN: ifid_bubble = BRANCH_TAKEN || !STALL;
      default: ifid_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      skid_q    <= 32'd0;
      skid_pc_q <= 32'd0;
      tgt_q     <= 32'd0;
      req_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          if (BRANCH_TAKEN) pc_q <= BRANCH_TARGET;
        end
        FETCH: begin
          if (BRANCH_TAKEN) begin
            // An outstanding request cannot be withdrawn, so drain it first
            if (IMEM_READY) pc_q <= BRANCH_TARGET;
            else begin
              tgt_q   <= BRANCH_TARGET;
              state_q <= DRAIN;
            end
          end else if (IMEM_READY) begin
            pc_q <= pc_q + PC_INC;
            if (STALL) begin
              skid_q    <= IMEM_RDATA;
              skid_pc_q <= pc_q;
              state_q   <= HOLD;
              req_q     <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (BRANCH_TAKEN) begin
            pc_q    <= BRANCH_TARGET;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else if (!STALL) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (IMEM_READY) begin
            pc_q    <= BRANCH_TAKEN ? BRANCH_TARGET : tgt_q;
            state_q <= FETCH;
          end else if (BRANCH_TAKEN) begin
            tgt_q <= BRANCH_TARGET;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  if_id_register u_if_id (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (ifid_instr),
    .pc_i       (ifid_pc),
    .instr_o    (INSTRUCTION),
    .pc_o       (PC_OUT),
    .pc_plus4_o (PC_PLUS4),
    .valid_o    (VALID)
  );

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign STATE_DBG = state_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (ifid_load)                fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (req_q && !IMEM_READY)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign FETCH_COUNT = fetch_cnt_q;
  assign STALL_COUNT = stall_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed cycles push expected IF/ID loads.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4;
  ifu_state_e  STATE_DBG;
  logic        VALID;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] FETCH_COUNT;
  logic [31:0] STALL_COUNT;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_e = 64'd0;
  logic        stall_s = 1'b0;

  instruction_fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_READY    (IMEM_READY),
    .IMEM_RDATA    (IMEM_RDATA),
    .INSTRUCTION   (INSTRUCTION),
    .PC_OUT        (PC_OUT),
    .PC_PLUS4      (PC_PLUS4),
    .STATE_DBG     (STATE_DBG),
    .VALID         (VALID)
`ifdef IFU_PERF_CNT_EN
    ,
    .FETCH_COUNT   (FETCH_COUNT),
    .STALL_COUNT   (STALL_COUNT)
`endif
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h00000014) return 32'h00A00093;
    return a ^ 32'hDEAD0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // Drive one cycle of inputs at posedge+1, then advance to the next posedge+1.
  task automatic step(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    IMEM_READY    = rdy;
    STALL         = stl;
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = tgt;
    IMEM_RDATA    = rdy ? mem_word(IMEM_ADDR) : 32'hBAD0BAD0;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_fetch(input logic [31:0] addr);
    check("imem_req", {31'd0, IMEM_REQ}, 32'd1);
    check("imem_addr", IMEM_ADDR, addr);
  endtask

  task automatic chk_noreq();
    check("imem_req_low", {31'd0, IMEM_REQ}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge CLK) stall_s <= STALL;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (VALID && !stall_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got pc %08h instr %08h expected no load", PC_OUT, INSTRUCTION);
        end else begin
          last_e = exp_q.pop_front();
          check("ifid_instr", INSTRUCTION, last_e[31:0]);
          check("ifid_pc", PC_OUT, last_e[63:32]);
          check("ifid_pc_plus4", PC_PLUS4, last_e[63:32] + 32'd4);
        end
      end else if (VALID && stall_s) begin
        check("hold_instr", INSTRUCTION, last_e[31:0]);
        check("hold_pc", PC_OUT, last_e[63:32]);
      end else begin
        check("bubble_nop", INSTRUCTION, 32'h00000013);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    STALL = 1'b0;
    BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = 32'd0;
    IMEM_READY = 1'b1;
    IMEM_RDATA = 32'd0;
    repeat (2) @(negedge CLK);
    check("rst_instr", INSTRUCTION, 32'h00000013);
    check("rst_valid", {31'd0, VALID}, 32'd0);
    check("rst_pc_out", PC_OUT, 32'd0);
    check("rst_pc_plus4", PC_PLUS4, 32'd4);
    check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    check("rst_state", 32'(STATE_DBG), 32'(IDLE));
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Sequential fetch with memory always ready
    chk_noreq();
    step(1, 0, 0, 0);
    chk_fetch(32'h0);  push_exp(32'h0);  step(1, 0, 0, 0);
    chk_fetch(32'h4);  push_exp(32'h4);  step(1, 0, 0, 0);
    chk_fetch(32'h8);  push_exp(32'h8);  step(1, 0, 0, 0);
    chk_fetch(32'hC);  push_exp(32'hC);  step(1, 0, 0, 0);

    // Three wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      chk_fetch(32'h10);
      step(0, 0, 0, 0);
    end
    chk_fetch(32'h10); push_exp(32'h10); step(1, 0, 0, 0);

    // Stall coincident with the response: skid buffer then release
    chk_fetch(32'h14);
    step(1, 1, 0, 0);
    chk_noreq();
    check("hold_state", 32'(STATE_DBG), 32'(HOLD));
    step(0, 1, 0, 0);
    chk_noreq();
    push_exp(32'h14);
    step(0, 0, 0, 0);
    chk_fetch(32'h18); push_exp(32'h18); step(1, 0, 0, 0);

    // Redirect while waiting, then an overriding redirect during drain
    chk_fetch(32'h1C);
    step(0, 0, 1, 32'h100);
    chk_fetch(32'h1C);
    check("drain_state", 32'(STATE_DBG), 32'(DRAIN));
    step(0, 0, 1, 32'h200);
    chk_fetch(32'h1C);
    step(1, 0, 0, 0);
    chk_fetch(32'h200); push_exp(32'h200); step(1, 0, 0, 0);

    // Redirect, stall and ready together; then a redirect out of HOLD
    chk_fetch(32'h204);
    step(1, 1, 1, 32'h200);
    chk_fetch(32'h200); push_exp(32'h200); step(1, 0, 0, 0);
    chk_fetch(32'h204);
    step(1, 1, 0, 0);
    chk_noreq();
    step(0, 0, 1, 32'h400);
    chk_fetch(32'h400); push_exp(32'h400); step(1, 0, 0, 0);

    // PC wrap-around
    chk_fetch(32'h404);
    step(1, 0, 1, 32'hFFFFFFF8);
    chk_fetch(32'hFFFFFFF8); push_exp(32'hFFFFFFF8); step(1, 0, 0, 0);
    chk_fetch(32'hFFFFFFFC); push_exp(32'hFFFFFFFC); step(1, 0, 0, 0);
    chk_fetch(32'h0);        push_exp(32'h0);        step(1, 0, 0, 0);

    // Reset in the middle of an outstanding request
    chk_fetch(32'h4);
    step(0, 0, 0, 0);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_req", {31'd0, IMEM_REQ}, 32'd0);
    check("midrst_valid", {31'd0, VALID}, 32'd0);
    check("midrst_state", 32'(STATE_DBG), 32'(IDLE));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    step(1, 0, 0, 0);
    chk_fetch(32'h0); push_exp(32'h0); step(1, 0, 0, 0);
    chk_fetch(32'h4); step(0, 0, 0, 0);
    chk_fetch(32'h4); step(0, 0, 0, 0);
    chk_fetch(32'h4); push_exp(32'h4); step(1, 0, 0, 0);
    #5;
`ifdef IFU_PERF_CNT_EN
    check("fetch_count", FETCH_COUNT, 32'd2);
    check("stall_count", STALL_COUNT, 32'd2);
`endif
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
